// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's result ports, issue port, scoreboard
// output and register-file write port.
interface wb_arbiter_if #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32
) ();
  logic                   a_valid;
  logic                   a_ready;
  logic [RFIDX_WIDTH-1:0] a_rd;
  logic [XLEN-1:0]        a_data;
  logic                   b_valid;
  logic                   b_ready;
  logic [RFIDX_WIDTH-1:0] b_rd;
  logic [XLEN-1:0]        b_data;
  logic                   iss_valid;
  logic [RFIDX_WIDTH-1:0] iss_rd;
  logic [RFREG_NUM-1:0]   busy;
  logic                   we3;
  logic [RFIDX_WIDTH-1:0] wa3;
  logic [XLEN-1:0]        wd3;

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
    output a_ready, b_ready, busy, we3, wa3, wd3
  );

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
    input  a_ready, b_ready, busy, we3, wa3, wd3
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle (A) and queued long-latency (B)
// results onto one register-file write port, with a per-register busy scoreboard.
module wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32,
  parameter int BUF_DEPTH   = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic         clk,
  input  logic         rstn,
  wb_arbiter_if.slave  bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [RFIDX_WIDTH-1:0] r_buf_rd   [BUF_DEPTH];
  logic [XLEN-1:0]        r_buf_data [BUF_DEPTH];
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [CW-1:0]          r_count;
  logic [SW-1:0]          r_starve;
  logic                   r_a_ready;
  logic [RFREG_NUM-1:0]   r_busy;
  logic                   r_we3;
  logic [RFIDX_WIDTH-1:0] r_wa3;
  logic [XLEN-1:0]        r_wd3;

  logic                   w_fifo_ne, w_a_win, w_pop, w_push, w_b_ready;
  logic [SW-1:0]          w_starve_nxt;
  logic [CW-1:0]          w_count_nxt;
  logic [RFREG_NUM-1:0]   w_busy_nxt;
  logic [RFIDX_WIDTH-1:0] w_head_rd;
  logic [XLEN-1:0]        w_head_data;

  always_comb begin
    w_fifo_ne   = (r_count != '0);
    w_b_ready   = (r_count < CW'(BUF_DEPTH));
    w_a_win     = r_a_ready && bus.a_valid && (bus.a_rd != '0);
    // While a_ready is held low a_win is false, so a non-empty FIFO pops here.
    w_pop       = !w_a_win && w_fifo_ne;
    w_push      = bus.b_valid && w_b_ready && (bus.b_rd != '0);
    w_head_rd   = r_buf_rd[r_rptr];
    w_head_data = r_buf_data[r_rptr];
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_starve_nxt = (w_a_win && w_fifo_ne) ? r_starve + SW'(1) : '0;
  end

  // Clear-then-set ordering makes a same-cycle issue win over a pop.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 1; i < RFREG_NUM; i++) begin
      if (w_pop && (w_head_rd == RFIDX_WIDTH'(i)))
        w_busy_nxt[i] = 1'b0;
      if (bus.iss_valid && (bus.iss_rd == RFIDX_WIDTH'(i)))
        w_busy_nxt[i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_rd[r_wptr]   <= bus.b_rd;
      r_buf_data[r_wptr] <= bus.b_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_a_ready <= 1'b1;
      r_busy    <= '0;
      r_we3     <= 1'b0;
      r_wa3     <= '0;
      r_wd3     <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count   <= w_count_nxt;
      r_starve  <= w_starve_nxt;
      r_a_ready <= (w_starve_nxt != SW'(STARVE_MAX));
      r_busy    <= w_busy_nxt;
      if (w_a_win) begin
        r_we3 <= 1'b1;
        r_wa3 <= bus.a_rd;
        r_wd3 <= bus.a_data;
      end else if (w_pop) begin
        r_we3 <= 1'b1;
        r_wa3 <= w_head_rd;
        r_wd3 <= w_head_data;
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end

  assign bus.a_ready = r_a_ready;
  assign bus.b_ready = w_b_ready;
  assign bus.busy    = r_busy;
  assign bus.we3     = r_we3;
  assign bus.wa3     = r_wa3;
  assign bus.wd3     = r_wd3;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int NREG = 32;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .RFREG_NUM(NREG)) bus ();

  wb_arbiter #(
    .XLEN(XLEN), .RFIDX_WIDTH(RW), .RFREG_NUM(NREG),
    .BUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            m_q[$];
  int              m_starve;
  logic            m_a_ready;
  logic [NREG-1:0] m_busy;
  logic            m_we;
  logic [RW-1:0]   m_wa;
  logic [XLEN-1:0] m_wd;
  bit              last_a_x, last_b_x;

  typedef struct {
    logic av; logic [RW-1:0] ard; logic [XLEN-1:0] adat;
    logic bv; logic [RW-1:0] brd; logic [XLEN-1:0] bdat;
    logic iv; logic [RW-1:0] ird;
    logic e_we; logic [RW-1:0] e_wa; logic [XLEN-1:0] e_wd;
    logic [NREG-1:0] e_busy; logic e_ar; logic e_br;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve  = 0;
    m_a_ready = 1'b1;
    m_busy    = '0;
    m_we      = 1'b0;
    m_wa      = '0;
    m_wd      = '0;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_rd = '0; bus.b_data = '0;
    bus.iss_valid = 0; bus.iss_rd = '0;
  endtask

  // Reference behaviour for one clock edge, from the arbitration rules.
  task automatic model_step();
    int   sz;
    bit   aw;
    ent_t e;
    sz = m_q.size();
    last_a_x = m_a_ready && bus.a_valid;
    last_b_x = bus.b_valid && (sz < DEPTH);
    aw = last_a_x && (bus.a_rd != 0);
    if (aw) begin
      m_we = 1; m_wa = bus.a_rd; m_wd = bus.a_data;
      m_starve = (sz > 0) ? m_starve + 1 : 0;
    end else if (sz > 0) begin
      e = m_q.pop_front();
      m_we = 1; m_wa = e.rd; m_wd = e.data;
      m_busy[e.rd] = 1'b0;
      m_starve = 0;
    end else begin
      m_we = 0;
    end
    if (last_b_x && bus.b_rd != 0) m_q.push_back('{bus.b_rd, bus.b_data});
    if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
    m_a_ready = (m_starve != SMAX);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("we3", bus.we3, m_we);
    if (m_we) begin
      chk("wa3", bus.wa3, m_wa);
      chk("wd3", bus.wd3, m_wd);
    end
    chk("busy", bus.busy, m_busy);
    chk("a_ready", bus.a_ready, m_a_ready);
    chk("b_ready", bus.b_ready, (m_q.size() < DEPTH));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    ent_t           got[$];
    int             idx;
    bit             saw_full;
    logic [RW-1:0]  r;
    bit             found;

    idle_inputs();
    model_reset();
    vecs[0] = '{1,5,32'hAA,        0,0,0,            0,0, 1,5,32'hAA,        32'h0,  1,1};
    vecs[1] = '{0,0,0,             0,0,0,            1,7, 0,0,0,             32'h80, 1,1};
    vecs[2] = '{0,0,0,             1,7,32'h12345678, 0,0, 0,0,0,             32'h80, 1,1};
    vecs[3] = '{0,0,0,             0,0,0,            0,0, 1,7,32'h12345678,  32'h0,  1,1};
    vecs[4] = '{1,0,32'hFFFFFFFF,  1,0,32'hFFFFFFFF, 0,0, 0,0,0,             32'h0,  1,1};
    vecs[5] = '{0,0,0,             0,0,0,            0,0, 0,0,0,             32'h0,  1,1};
    vecs[6] = '{1,3,32'h3,         1,9,32'h1,        0,0, 1,3,32'h3,         32'h0,  1,1};

    do_reset();
    chk("rst_we3", bus.we3, 0);
    chk("rst_wa3", bus.wa3, 0);
    chk("rst_wd3", bus.wd3, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_a_ready", bus.a_ready, 1);
    chk("rst_b_ready", bus.b_ready, 1);

    for (int i = 0; i < 7; i++) begin
      bus.a_valid = vecs[i].av; bus.a_rd = vecs[i].ard; bus.a_data = vecs[i].adat;
      bus.b_valid = vecs[i].bv; bus.b_rd = vecs[i].brd; bus.b_data = vecs[i].bdat;
      bus.iss_valid = vecs[i].iv; bus.iss_rd = vecs[i].ird;
      cycle();
      chk($sformatf("tbl%0d_we3", i), bus.we3, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("tbl%0d_wa3", i), bus.wa3, vecs[i].e_wa);
        chk($sformatf("tbl%0d_wd3", i), bus.wd3, vecs[i].e_wd);
      end
      chk($sformatf("tbl%0d_busy", i), bus.busy, vecs[i].e_busy);
      chk($sformatf("tbl%0d_a_ready", i), bus.a_ready, vecs[i].e_ar);
      chk($sformatf("tbl%0d_b_ready", i), bus.b_ready, vecs[i].e_br);
    end

    // Starvation: one B entry queued behind a saturating port A.
    do_reset();
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h3000;
    bus.b_valid = 1; bus.b_rd = 9; bus.b_data = 32'h99;
    for (int k = 0; k < 7; k++) begin
      cycle();
      bus.b_valid = 0;
      chk($sformatf("starve%0d_a_ready", k), bus.a_ready, (k == 4) ? 1'b0 : 1'b1);
      chk($sformatf("starve%0d_we3", k), bus.we3, 1);
      chk($sformatf("starve%0d_wa3", k), bus.wa3, (k == 5) ? 5'd9 : 5'd3);
      chk($sformatf("starve%0d_wd3", k), bus.wd3, (k == 5) ? 32'h99 : 32'h3000);
    end

    // FIFO full: three B results back-to-back while A saturates.
    do_reset();
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h3000;
    idx = 0; saw_full = 0;
    got.delete();
    for (int t = 0; t < 60 && got.size() < 3; t++) begin
      bus.b_valid = (idx < 3);
      bus.b_rd = RW'(10 + idx); bus.b_data = 32'hB0 + idx;
      cycle();
      if (last_b_x && idx < 3) begin
        idx++;
        if (idx == 3) chk("full_push3_after_pop", (got.size() >= 1), 1);
      end
      if (idx == 2 && !saw_full) begin
        saw_full = 1;
        chk("full_b_ready_low", bus.b_ready, 0);
      end
      if (bus.we3 && bus.wa3 != 3) got.push_back('{bus.wa3, bus.wd3});
    end
    chk("full_pop_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) begin
      chk($sformatf("full_order%0d_rd", i), got[i].rd, 10 + i);
      chk($sformatf("full_order%0d_data", i), got[i].data, 32'hB0 + i);
    end

    // Asynchronous reset with two queued entries and busy[9] set.
    do_reset();
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h3000;
    bus.b_valid = 1; bus.b_rd = 9; bus.b_data = 32'h99;
    bus.iss_valid = 1; bus.iss_rd = 9;
    cycle();
    bus.iss_valid = 0;
    bus.b_rd = 10; bus.b_data = 32'hAA;
    cycle();
    chk("arst_pre_full", bus.b_ready, 0);
    chk("arst_pre_busy9", bus.busy[9], 1);
    #2 rstn = 0;
    #1;
    chk("arst_we3", bus.we3, 0);
    chk("arst_wa3", bus.wa3, 0);
    chk("arst_wd3", bus.wd3, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_a_ready", bus.a_ready, 1);
    chk("arst_b_ready", bus.b_ready, 1);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rstn = 1;
    repeat (4) begin
      cycle();
      chk("arst_no_stale_write", bus.we3, 0);
    end

    // Randomized traffic honouring the producer and decode contracts.
    do_reset();
    last_a_x = 1; last_b_x = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!bus.a_valid || last_a_x) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_data  = $urandom;
        bus.a_rd    = '0;
        if ($urandom_range(0, 7) != 0) begin
          for (int t = 0; t < 40; t++) begin
            r = RW'($urandom_range(1, NREG - 1));
            if (!m_busy[r]) begin bus.a_rd = r; break; end
          end
        end
      end
      if (!bus.b_valid || last_b_x) begin
        bus.b_valid = ($urandom_range(0, 2) == 0);
        bus.b_rd    = RW'($urandom_range(0, NREG - 1));
        bus.b_data  = $urandom;
      end
      found = 0;
      if ($urandom_range(0, 3) == 0) begin
        for (int t = 0; t < 40 && !found; t++) begin
          r = RW'($urandom_range(1, NREG - 1));
          if (!m_busy[r] && !(bus.a_valid && bus.a_rd == r)) begin
            found = 1;
            bus.iss_rd = r;
          end
        end
      end
      bus.iss_valid = found;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
